vrf_writeback_stage: RTL and testbench



---
 rtl/vrf_writeback_stage.sv | 191 +++++++++++++++++++
 tb/tb_vrf_writeback_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_writeback_stage.sv
// Lane writeback stage: per-source result FIFOs arbitrated round-robin onto the
// single VRF write port, with a one-cycle "written" pulse back to each source.
module vrf_writeback_stage #(
  parameter int NrSources = 5,
  parameter int BufDepth  = 2,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 3,
  localparam int BeWidth  = DataWidth / 8,
  localparam int SrcWidth = (NrSources > 1) ? $clog2(NrSources) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrSources-1:0]                 result_req_i,
  input  logic [NrSources-1:0][AddrWidth-1:0]  result_addr_i,
  input  logic [NrSources-1:0][DataWidth-1:0]  result_wdata_i,
  input  logic [NrSources-1:0][BeWidth-1:0]    result_be_i,
  input  logic [NrSources-1:0][IdWidth-1:0]    result_id_i,
  output logic [NrSources-1:0]                 result_gnt_o,
  output logic [NrSources-1:0]                 result_written_o,
  output logic [NrSources-1:0][IdWidth-1:0]    result_written_id_o,
  output logic                                 vrf_wr_valid_o,
  input  logic                                 vrf_wr_ready_i,
  output logic [AddrWidth-1:0]                 vrf_wr_addr_o,
  output logic [DataWidth-1:0]                 vrf_wr_data_o,
  output logic [BeWidth-1:0]                   vrf_wr_be_o,
  output logic [SrcWidth-1:0]                  vrf_wr_src_o
);

  localparam int CntWidth = $clog2(BufDepth + 1);
  localparam int PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(BufDepth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(BufDepth - 1);
  localparam logic [SrcWidth-1:0] LastSrc = SrcWidth'(NrSources - 1);
  localparam logic [SrcWidth:0]   NrSrcW  = (SrcWidth + 1)'(NrSources);

  logic [NrSources-1:0]                not_empty;
  logic [NrSources-1:0]                pop_vec;
  logic [NrSources-1:0][AddrWidth-1:0] head_addr;
  logic [NrSources-1:0][DataWidth-1:0] head_data;
  logic [NrSources-1:0][BeWidth-1:0]   head_be;
  logic [NrSources-1:0][IdWidth-1:0]   head_id;

  logic [SrcWidth-1:0] rr_q, rr_next;
  logic                lock_q, lock_next;
  logic [SrcWidth-1:0] lock_src_q, lock_src_next;
  logic                arb_found;
  logic [SrcWidth-1:0] arb_src;
  logic [SrcWidth-1:0] sel_src;
  logic                wr_valid;
  logic                handshake;

  logic [NrSources-1:0]              written_q;
  logic [NrSources-1:0][IdWidth-1:0] written_id_q;

  // Per-source FIFOs; grant depends only on the registered fill count.
  for (genvar gi = 0; gi < NrSources; gi++) begin : g_fifo
    logic [AddrWidth-1:0] addr_mem [BufDepth];
    logic [DataWidth-1:0] data_mem [BufDepth];
    logic [BeWidth-1:0]   be_mem   [BufDepth];
    logic [IdWidth-1:0]   id_mem   [BufDepth];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 push;
    logic                 pop;

    assign push = result_req_i[gi] & result_gnt_o[gi];
    assign pop  = pop_vec[gi];

    always_ff @(posedge clk_i) begin
      if (push) begin
        addr_mem[wr_ptr_q] <= result_addr_i[gi];
        data_mem[wr_ptr_q] <= result_wdata_i[gi];
        be_mem[wr_ptr_q]   <= result_be_i[gi];
        id_mem[wr_ptr_q]   <= result_id_i[gi];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end

    assign result_gnt_o[gi] = (count_q != FullCnt);
    assign not_empty[gi]    = (count_q != '0);
    assign head_addr[gi]    = addr_mem[rd_ptr_q];
    assign head_data[gi]    = data_mem[rd_ptr_q];
    assign head_be[gi]      = be_mem[rd_ptr_q];
    assign head_id[gi]      = id_mem[rd_ptr_q];
    assign pop_vec[gi]      = handshake && (sel_src == SrcWidth'(gi));
  end

  // Round-robin search starting at rr_q, wrapping with an explicit compare.
  always_comb begin : arb
    logic [SrcWidth:0]   sum;
    logic [SrcWidth-1:0] idx;
    arb_found = 1'b0;
    arb_src   = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NrSources; i++) begin
      sum = {1'b0, rr_q} + (SrcWidth + 1)'(i);
      if (sum >= NrSrcW) begin
        sum = sum - NrSrcW;
      end
      idx = sum[SrcWidth-1:0];
      if (!arb_found && not_empty[idx]) begin
        arb_found = 1'b1;
        arb_src   = idx;
      end
    end
  end

  assign sel_src   = lock_q ? lock_src_q : arb_src;
  assign wr_valid  = lock_q | arb_found;
  assign handshake = wr_valid & vrf_wr_ready_i;

  // Lock/pointer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= '0;
    end else begin
      rr_q       <= rr_next;
      lock_q     <= lock_next;
      lock_src_q <= lock_src_next;
    end
  end

  // Next state: a stalled request pins the selection until it is accepted.
  always_comb begin
    rr_next       = rr_q;
    lock_next     = lock_q;
    lock_src_next = lock_src_q;
    if (handshake) begin
      rr_next   = (sel_src == LastSrc) ? '0 : sel_src + 1'b1;
      lock_next = 1'b0;
    end else if (wr_valid) begin
      lock_next     = 1'b1;
      lock_src_next = sel_src;
    end
  end

  // Outputs: selected head, forced to zero when idle.
  always_comb begin
    vrf_wr_valid_o = wr_valid;
    vrf_wr_addr_o  = '0;
    vrf_wr_data_o  = '0;
    vrf_wr_be_o    = '0;
    vrf_wr_src_o   = '0;
    if (wr_valid) begin
      vrf_wr_addr_o = head_addr[sel_src];
      vrf_wr_data_o = head_data[sel_src];
      vrf_wr_be_o   = head_be[sel_src];
      vrf_wr_src_o  = sel_src;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      written_q    <= '0;
      written_id_q <= '0;
    end else begin
      written_q <= pop_vec;
      for (int s = 0; s < NrSources; s++) begin
        written_id_q[s] <= pop_vec[s] ? head_id[s] : '0;
      end
    end
  end

  assign result_written_o    = written_q;
  assign result_written_id_o = written_id_q;

endmodule

// File: tb/tb_vrf_writeback_stage.sv
// Directed bench for vrf_writeback_stage: table of single writes plus
// hand-written sequences for backpressure, round-robin, stalls, reset, streaming.
module tb_vrf_writeback_stage;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       result_req_i;
  logic [4:0][15:0] result_addr_i;
  logic [4:0][63:0] result_wdata_i;
  logic [4:0][7:0]  result_be_i;
  logic [4:0][2:0]  result_id_i;
  logic [4:0]       result_gnt_o;
  logic [4:0]       result_written_o;
  logic [4:0][2:0]  result_written_id_o;
  logic             vrf_wr_valid_o;
  logic             vrf_wr_ready_i;
  logic [15:0]      vrf_wr_addr_o;
  logic [63:0]      vrf_wr_data_o;
  logic [7:0]       vrf_wr_be_o;
  logic [2:0]       vrf_wr_src_o;

  int checks = 0;
  int errors = 0;

  vrf_writeback_stage dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .result_req_i        (result_req_i),
    .result_addr_i       (result_addr_i),
    .result_wdata_i      (result_wdata_i),
    .result_be_i         (result_be_i),
    .result_id_i         (result_id_i),
    .result_gnt_o        (result_gnt_o),
    .result_written_o    (result_written_o),
    .result_written_id_o (result_written_id_o),
    .vrf_wr_valid_o      (vrf_wr_valid_o),
    .vrf_wr_ready_i      (vrf_wr_ready_i),
    .vrf_wr_addr_o       (vrf_wr_addr_o),
    .vrf_wr_data_o       (vrf_wr_data_o),
    .vrf_wr_be_o         (vrf_wr_be_o),
    .vrf_wr_src_o        (vrf_wr_src_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          src;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [2:0]  id;
    logic [2:0]  exp_src;
    logic [4:0]  exp_written;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put(input int s, input logic [15:0] a, input logic [63:0] d,
                     input logic [7:0] b, input logic [2:0] i);
    result_req_i[s]   = 1'b1;
    result_addr_i[s]  = a;
    result_wdata_i[s] = d;
    result_be_i[s]    = b;
    result_id_i[s]    = i;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    result_req_i = '0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{src: 1, addr: 16'h0040, data: 64'hDEADBEEF_00000001, be: 8'hFF, id: 3'd3,
                exp_src: 3'd1, exp_written: 5'b00010};
    vecs[1] = '{src: 0, addr: 16'h1234, data: 64'h0123_4567_89AB_CDEF, be: 8'h00, id: 3'd0,
                exp_src: 3'd0, exp_written: 5'b00001};
    vecs[2] = '{src: 4, addr: 16'hFFFF, data: 64'hFFFF_FFFF_FFFF_FFFF, be: 8'h0F, id: 3'd7,
                exp_src: 3'd4, exp_written: 5'b10000};
    vecs[3] = '{src: 3, addr: 16'h0008, data: 64'h0, be: 8'h81, id: 3'd5,
                exp_src: 3'd3, exp_written: 5'b01000};
    vecs[4] = '{src: 2, addr: 16'hA5A5, data: 64'h5A5A_5A5A_0000_FFFF, be: 8'hF0, id: 3'd2,
                exp_src: 3'd2, exp_written: 5'b00100};

    rst_i = 1'b1;
    vrf_wr_ready_i = 1'b0;
    result_req_i = '0;
    result_addr_i = '0;
    result_wdata_i = '0;
    result_be_i = '0;
    result_id_i = '0;
    tick();
    tick();
    chk("rst_valid", 64'(vrf_wr_valid_o), 64'h0);
    chk("rst_gnt", 64'(result_gnt_o), 64'h1F);
    chk("rst_addr", 64'(vrf_wr_addr_o), 64'h0);
    chk("rst_data", vrf_wr_data_o, 64'h0);
    chk("rst_be", 64'(vrf_wr_be_o), 64'h0);
    chk("rst_src", 64'(vrf_wr_src_o), 64'h0);
    chk("rst_written", 64'(result_written_o), 64'h0);
    chk("rst_written_id", 64'(result_written_id_o), 64'h0);
    rst_i = 1'b0;

    // Table: isolated single writes, ready held high.
    vrf_wr_ready_i = 1'b1;
    for (int v = 0; v < 5; v++) begin
      put(vecs[v].src, vecs[v].addr, vecs[v].data, vecs[v].be, vecs[v].id);
      tick();
      result_req_i = '0;
      chk("vec_valid", 64'(vrf_wr_valid_o), 64'h1);
      chk("vec_src", 64'(vrf_wr_src_o), 64'(vecs[v].exp_src));
      chk("vec_addr", 64'(vrf_wr_addr_o), 64'(vecs[v].addr));
      chk("vec_data", vrf_wr_data_o, vecs[v].data);
      chk("vec_be", 64'(vrf_wr_be_o), 64'(vecs[v].be));
      chk("vec_written_early", 64'(result_written_o), 64'h0);
      tick();
      chk("vec_written", 64'(result_written_o), 64'(vecs[v].exp_written));
      chk("vec_written_id", 64'(result_written_id_o[vecs[v].src]), 64'(vecs[v].id));
      chk("vec_idle", 64'(vrf_wr_valid_o), 64'h0);
      tick();
      chk("vec_pulse_width", 64'(result_written_o), 64'h0);
      $display("vec %0d: src %0d addr 0x%0h be 0x%0h id %0d", v, vecs[v].src,
               vecs[v].addr, vecs[v].be, vecs[v].id);
    end

    // Full backpressure on src 0 with depth 2.
    vrf_wr_ready_i = 1'b0;
    put(0, 16'h0100, 64'h1, 8'hFF, 3'd1);
    tick();
    chk("bp_gnt_after1", 64'(result_gnt_o[0]), 64'h1);
    put(0, 16'h0101, 64'h2, 8'hFF, 3'd2);
    tick();
    chk("bp_gnt_full", 64'(result_gnt_o[0]), 64'h0);
    chk("bp_head1", 64'(vrf_wr_addr_o), 64'h0100);
    put(0, 16'h0102, 64'h3, 8'hFF, 3'd3);
    tick();
    chk("bp_gnt_still_full", 64'(result_gnt_o[0]), 64'h0);
    chk("bp_head1_stall", 64'(vrf_wr_addr_o), 64'h0100);
    vrf_wr_ready_i = 1'b1;
    tick();
    chk("bp_written1", 64'(result_written_id_o[0]), 64'h1);
    chk("bp_head2", 64'(vrf_wr_addr_o), 64'h0101);
    chk("bp_gnt_reopen", 64'(result_gnt_o[0]), 64'h1);
    tick();
    result_req_i = '0;
    chk("bp_written2", 64'(result_written_id_o[0]), 64'h2);
    chk("bp_head3", 64'(vrf_wr_addr_o), 64'h0102);
    chk("bp_data3", vrf_wr_data_o, 64'h3);
    tick();
    chk("bp_written3", 64'(result_written_id_o[0]), 64'h3);
    chk("bp_idle", 64'(vrf_wr_valid_o), 64'h0);
    $display("backpressure: 3 writes on src 0");

    // Round-robin from a fresh pointer.
    do_reset();
    for (int s = 0; s < 5; s++) put(s, 16'h0200 + 16'(s), 64'(s), 8'hFF, 3'(s + 1));
    tick();
    result_req_i = '0;
    for (int s = 0; s < 5; s++) begin
      chk("rr_src", 64'(vrf_wr_src_o), 64'(s));
      chk("rr_addr", 64'(vrf_wr_addr_o), 64'h0200 + 64'(s));
      tick();
      chk("rr_written", 64'(result_written_o), 64'(5'b00001 << s));
      chk("rr_written_id", 64'(result_written_id_o[s]), 64'(s + 1));
      $display("rr: served src %0d", s);
    end
    chk("rr_idle", 64'(vrf_wr_valid_o), 64'h0);
    put(0, 16'h0210, 64'h10, 8'hFF, 3'd6);
    put(2, 16'h0212, 64'h12, 8'hFF, 3'd7);
    tick();
    result_req_i = '0;
    chk("rr2_first", 64'(vrf_wr_src_o), 64'h0);
    tick();
    chk("rr2_second", 64'(vrf_wr_src_o), 64'h2);
    tick();
    chk("rr2_idle", 64'(vrf_wr_valid_o), 64'h0);
    $display("rr: reload served 0 then 2");

    // Stall stability: pointer now favours src 0 over src 2, lock must hold 2.
    vrf_wr_ready_i = 1'b0;
    put(2, 16'h0220, 64'hCAFE_0002, 8'h3C, 3'd5);
    tick();
    result_req_i = '0;
    put(0, 16'h0230, 64'hCAFE_0000, 8'hFF, 3'd4);
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", 64'(vrf_wr_valid_o), 64'h1);
      chk("stall_src", 64'(vrf_wr_src_o), 64'h2);
      chk("stall_addr", 64'(vrf_wr_addr_o), 64'h0220);
      chk("stall_data", vrf_wr_data_o, 64'hCAFE_0002);
      chk("stall_be", 64'(vrf_wr_be_o), 64'h3C);
      tick();
      result_req_i = '0;
    end
    vrf_wr_ready_i = 1'b1;
    tick();
    chk("stall_written2", 64'(result_written_o), 64'b00100);
    chk("stall_next_src", 64'(vrf_wr_src_o), 64'h0);
    chk("stall_next_addr", 64'(vrf_wr_addr_o), 64'h0230);
    tick();
    chk("stall_written0", 64'(result_written_o), 64'b00001);
    chk("stall_written0_id", 64'(result_written_id_o[0]), 64'h4);
    $display("stall: src 2 held, then src 0");

    // Reset mid-operation, with rr pointer at 1 beforehand.
    vrf_wr_ready_i = 1'b0;
    put(1, 16'h0301, 64'h1, 8'hFF, 3'd1);
    put(3, 16'h0303, 64'h3, 8'hFF, 3'd3);
    put(4, 16'h0304, 64'h4, 8'hFF, 3'd4);
    tick();
    result_req_i = '0;
    chk("mrst_pre_src", 64'(vrf_wr_src_o), 64'h1);
    tick();
    do_reset();
    chk("mrst_valid", 64'(vrf_wr_valid_o), 64'h0);
    chk("mrst_gnt", 64'(result_gnt_o), 64'h1F);
    chk("mrst_written", 64'(result_written_o), 64'h0);
    vrf_wr_ready_i = 1'b1;
    tick();
    chk("mrst_valid2", 64'(vrf_wr_valid_o), 64'h0);
    chk("mrst_written2", 64'(result_written_o), 64'h0);
    put(0, 16'h0310, 64'h10, 8'hFF, 3'd2);
    put(1, 16'h0311, 64'h11, 8'hFF, 3'd6);
    tick();
    result_req_i = '0;
    chk("mrst_rr0_src", 64'(vrf_wr_src_o), 64'h0);
    tick();
    chk("mrst_written_a", 64'(result_written_o), 64'b00001);
    chk("mrst_second_src", 64'(vrf_wr_src_o), 64'h1);
    tick();
    chk("mrst_written_b", 64'(result_written_o), 64'b00010);
    chk("mrst_written_b_id", 64'(result_written_id_o[1]), 64'h6);
    $display("reset mid-operation: buffered entries dropped");

    // Streaming on src 3.
    vrf_wr_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      put(3, 16'h0300 + 16'(k), 64'(k) * 64'h101, 8'hFF, 3'(k % 8));
      tick();
      chk("stream_gnt", 64'(result_gnt_o[3]), 64'h1);
      chk("stream_addr", 64'(vrf_wr_addr_o), 64'h0300 + 64'(k));
      chk("stream_data", vrf_wr_data_o, 64'(k) * 64'h101);
      if (k > 0) begin
        chk("stream_written", 64'(result_written_o), 64'b01000);
        chk("stream_written_id", 64'(result_written_id_o[3]), 64'((k - 1) % 8));
      end
      $display("stream: beat %0d addr 0x%0h", k, vrf_wr_addr_o);
    end
    result_req_i = '0;
    tick();
    chk("stream_last_written", 64'(result_written_o), 64'b01000);
    chk("stream_last_id", 64'(result_written_id_o[3]), 64'h3);
    chk("stream_idle", 64'(vrf_wr_valid_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
